// File: rtl/gate_shift_seq_pkg.sv
// Shared definitions for the bit-serial gate/shift sequencer: op codes,
// FSM states and the direction/rotate encodings.
package gate_shift_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic ROT_LOGICAL = 1'b0;
  localparam logic ROT_ROTATE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/gate_shift_seq_if.sv
// Operand/result handshake bundle of the sequencer; the producer/consumer
// side uses the master modport, the sequencer itself the slave modport.
interface gate_shift_seq_if #(
  parameter int WIDTH = 4
);

  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic             dir;
  logic             rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, a, b, op, shamt, dir, rot, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, op, shamt, dir, rot, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/gate_shift_seq_gate_bit.sv
// Combinational 1-bit logic gate with op select; the sequencer time-shares
// a single instance across all operand bits.
module gate_bit
  import gate_shift_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/gate_shift_seq.sv
// Bit-serial logic-and-shift sequencer: evaluates one gate bit per cycle,
// then shifts/rotates the assembled word one position per cycle.
module gate_shift_seq
  import gate_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_shift_seq_if.slave    bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [SHW-1:0]   sh_cnt_q, sh_cnt_d;
  logic             gate_y;

  gate_bit u_gate_bit (
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .op (op_q),
    .y  (gate_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      dir_q    <= 1'b0;
      rot_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sh_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      dir_q    <= dir_d;
      rot_q    <= rot_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sh_cnt_q <= sh_cnt_d;
    end
  end

  // The shift counter is loaded with shamt at accept so SHIFT can run straight off it.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    dir_d    = dir_q;
    rot_d    = rot_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sh_cnt_d = sh_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          op_d     = bus.op;
          dir_d    = bus.dir;
          rot_d    = bus.rot;
          sh_cnt_d = bus.shamt;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = EVAL;
        end
      end

      EVAL: begin
        acc_d[cnt_q] = gate_y;
        cnt_d        = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = (sh_cnt_q != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        if (dir_q == DIR_RIGHT) begin
          acc_d = {(rot_q == ROT_ROTATE) ? acc_q[0] : 1'b0, acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], (rot_q == ROT_ROTATE) ? acc_q[WIDTH-1] : 1'b0};
        end
        sh_cnt_d = sh_cnt_q - SHW'(1);
        if (sh_cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == EVAL) || (state_q == SHIFT);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = acc_q;

endmodule

// File: tb/tb_gate_shift_seq.sv
// Scoreboard bench for gate_shift_seq: directed bundles push expected
// results, a negedge monitor pops and compares on each result presentation.
module tb_gate_shift_seq;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0] res;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t q[$];

  gate_shift_seq_if #(.WIDTH(4)) bus ();

  gate_shift_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Called at a negedge; returns after the accept edge, at the following negedge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                               input logic [1:0] sh, input logic d, input logic r,
                               input logic [3:0] exp_res, input bit push, output int waited);
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.shamt    = sh;
    bus.dir      = d;
    bus.rot      = r;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) q.push_back('{exp_res, 4 + int'(sh), cyc});
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(bus.in_ready && q.size() == 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_idle", bus.in_ready && (q.size() == 0), 1);
  endtask

  // Monitor: pops on each rising out_valid, then checks the result is held.
  initial begin
    exp_t cur;
    bit   have_cur;
    bit   prev_valid;
    have_cur   = 0;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (!prev_valid) begin
          checkOutput("scoreboard_nonempty", q.size() != 0, 1);
          have_cur = (q.size() != 0);
          if (have_cur) begin
            cur = q.pop_front();
            checkOutput("result", bus.result, cur.res);
            checkOutput("latency", cyc - cur.acc_cyc, cur.lat);
          end
        end else if (have_cur) begin
          checkOutput("result_hold", bus.result, cur.res);
        end
        checkOutput("in_ready_in_done", bus.in_ready, 0);
        checkOutput("busy_in_done", bus.busy, 0);
      end
      prev_valid = rst_n && bus.out_valid;
    end
  end

  initial begin
    int w;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.shamt     = '0;
    bus.dir       = 1'b0;
    bus.rot       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] NAND, no shift");
    applyStimulus(4'b1100, 4'b1010, 3'd2, 2'd0, 1'b0, 1'b0, 4'b0111, 1, w);
    waitIdle();

    $display("[TB] XOR, logical left 1");
    applyStimulus(4'b1100, 4'b1010, 3'd4, 2'd1, 1'b0, 1'b0, 4'b1100, 1, w);
    waitIdle();

    $display("[TB] asynchronous reset in IDLE");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_result", bus.result, 4'b0000);
    checkOutput("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] AND, rotate right 3");
    applyStimulus(4'b1111, 4'b1001, 3'd0, 2'd3, 1'b1, 1'b1, 4'b0011, 1, w);
    waitIdle();

    $display("[TB] AND, logical right 3");
    applyStimulus(4'b1111, 4'b1001, 3'd0, 2'd3, 1'b1, 1'b0, 4'b0001, 1, w);
    waitIdle();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(4'b1100, 4'b1010, 3'd2, 2'd0, 1'b0, 1'b0, 4'b0111, 1, w);
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("bp_reach_done", bus.out_valid, 1);
    bus.a        = 4'b0011;
    bus.b        = 4'b0011;
    bus.op       = 3'd1;
    bus.shamt    = 2'd1;
    bus.dir      = 1'b0;
    bus.rot      = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_out_valid", bus.out_valid, 1);
      checkOutput("bp_result", bus.result, 4'b0111);
    end
    bus.out_ready = 1'b1;
    applyStimulus(4'b0011, 4'b0011, 3'd1, 2'd1, 1'b0, 1'b0, 4'b0110, 1, w);
    checkOutput("bp_idle_next_cycle", w, 1);
    waitIdle();

    $display("[TB] reset mid-EVAL");
    applyStimulus(4'b1111, 4'b1111, 3'd0, 2'd0, 1'b0, 1'b0, 4'b1111, 0, w);
    @(posedge clk);
    #1;
    checkOutput("mid_eval_busy", bus.busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", bus.in_ready, 1);
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    checkOutput("mid_rst_result", bus.result, 4'b0000);
    checkOutput("mid_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checkOutput("post_rst_no_out_valid", bus.out_valid, 0);
    end

    $display("[TB] NOT a after reset");
    applyStimulus(4'b0101, 4'b0000, 3'd6, 2'd0, 1'b0, 1'b0, 4'b1010, 1, w);
    waitIdle();

    checkOutput("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_shift_seq.md
# gate_shift_seq

Bit-serial logic-and-shift sequencer that sits directly downstream of the 1-bit logic gate cells. It accepts two 4-bit operands and an op select through a valid/ready handshake. It evaluates the selected gate one bit per cycle through a single 1-bit gate instance, shifts or rotates the assembled word one position per cycle, and presents the result through a valid/ready handshake.

## Interface
- `WIDTH`, default 4: operand/result width; shift amount width is `$clog2(WIDTH)`.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand bundle valid.
- `in_ready`  output  1  block can accept; high only in IDLE.
- `a`, `b`  input  WIDTH  operands.
- `op`  input  3  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 pass a.
- `shamt`  input  $clog2(WIDTH)  shift amount, 0..WIDTH-1.
- `dir`  input  1  0 left, 1 right.
- `rot`  input  1  0 logical (zero fill), 1 rotate.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `result`  output  WIDTH  gate result after shift.
- `busy`  output  1  high in EVAL or SHIFT.

## Operation
- FSM states are IDLE, EVAL, SHIFT, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register a, b, op, shamt, dir, rot, clear the accumulator, set bit counter=0, and go to EVAL.
- EVAL
  - Each cycle, `gate_bit(a[cnt], b[cnt], op)` is written into acc[cnt] and cnt increments.
  - After bit WIDTH-1 is written, go to SHIFT if shamt≠0, else go to DONE.
- SHIFT
  - Each cycle acc shifts one position in `dir`.
  - Logical shifts fill with 0. Rotates wrap the MSB/LSB.
  - A shift counter loads shamt and decrements. The transition to DONE occurs on the edge that performs the last shift.
- DONE
  - `out_valid`=1 and `result`=acc, both held stable until `out_valid`&&`out_ready` is sampled.
  - Then return to IDLE.
  - `in_ready` is low in DONE, so no accept is possible in the same cycle as the output handshake.
- Inputs are ignored outside IDLE. Changes on a, b, op etc. while busy have no effect.
- All 8 op codes are defined. There is no illegal-op handling.
- Reset values: state IDLE, acc/`result`=0, `out_valid`=0, `busy`=0, `in_ready`=1, counters 0.
- Reset mid-operation aborts immediately. No partial result is ever presented.

## Timing
- Accept at edge T.
  - EVAL occupies edges T+1..T+WIDTH.
  - SHIFT occupies the next shamt edges.
  - `out_valid` rises after edge T+WIDTH+shamt.
- Latency from accept to `out_valid` is WIDTH+shamt cycles: 4 to 7 for WIDTH=4.
- With `out_ready` held high, DONE lasts 1 cycle. `in_ready` returns the cycle after the output handshake.
- Minimum initiation interval is WIDTH+shamt+2 cycles.
- `in_ready`, `busy` and `out_valid` are decoded from registered state only, with no combinational path from inputs.
- `result` is registered. It keeps its value in IDLE until the next accept clears acc.

## Structure
- Package `gate_shift_pkg` holds:
  - the op code localparams (OP_AND … OP_PASS);
  - the state enum (IDLE/EVAL/SHIFT/DONE);
  - the dir/rot encodings.
- Sub-module `gate_bit` is a combinational 1-bit gate with op select. It is instantiated once, and the top-level block uses it serially.
- The top level holds the FSM, counters, operand registers and accumulator.

## Test plan
- Reset: assert `rst_n`=0 mid-simulation.
  - Required: `in_ready`=1, `out_valid`=0, `result`=0000, `busy`=0, independent of `clk`.
- NAND, no shift: a=1100, b=1010, op=2, shamt=0.
  - Required: `out_valid` 4 cycles after accept, `result`=0111.
- XOR, logical left 1: a=1100, b=1010, op=4, shamt=1, dir=0, rot=0.
  - Required: `result`=1100 after 5 cycles.
- AND, rotate right 3: a=1111, b=1001, op=0, shamt=3, dir=1, rot=1.
  - Required: `result`=0011 after 7 cycles.
  - Same stimulus with rot=0. Required: `result`=0001.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with new operands.
  - Required: `result`/`out_valid` stable, `in_ready`=0, new operands ignored.
  - Then raise `out_ready`. Required: IDLE next cycle and the new bundle is accepted.
- Reset mid-EVAL: pulse `rst_n` low after 2 EVAL cycles.
  - Required: immediate return to reset values and no `out_valid`.
  - Next transaction NOT a=0101 (op=6). Required: `result`=1010.
